// File: rtl/req_pending_sequencer.sv
// req_pending_sequencer
// Upstream stage of the 16-bit priority encoder. Request pulses are captured
// into sticky pending bits. The encoder's code for the pending vector comes
// back on enc_code, and the winning index is offered to a consumer over
// valid/ready. Acceptance clears the served bit and starts an optional idle
// gap. Requests that land on a bit that is already pending are counted in a
// saturating lost counter.
// Optional build macro: REQ_SYNC_EN puts req_in through a 2-flop
// synchronizer, which adds two cycles of request latency.
module req_pending_sequencer #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned LOST_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [15:0]       req_in,
  output logic [15:0]       pending,
  input  logic [7:0]        enc_code,
  output logic              svc_valid,
  output logic [3:0]        svc_index,
  input  logic              svc_ready,
  output logic [LOST_W-1:0] lost_cnt,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [3:0]        GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
  localparam logic [LOST_W-1:0] LOST_ONE = LOST_W'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_gap_cnt;
  logic [3:0]         w_gap_nxt;
  logic               w_latch_idx;
  logic [15:0]        r_pending;
  logic [3:0]         r_svc_index;
  logic [LOST_W-1:0]  r_lost;
  logic [15:0]        w_req;
  logic               w_code_valid;
  logic               w_hs;
  logic [15:0]        w_clr_mask;
  logic               w_lost_hit;

`ifdef REQ_SYNC_EN
  logic [15:0] r_sync1;
  logic [15:0] r_sync2;

  // Two-stage synchronizer for asynchronous request lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else if (ena) begin
      r_sync1 <= req_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_req = r_sync2;
`else
  assign w_req = req_in;
`endif

  // Any code with a nonzero upper nibble (0xF0 included) means no request.
  assign w_code_valid = (enc_code[7:4] == 4'h0);
  assign w_hs         = svc_valid & svc_ready;
  assign w_clr_mask   = w_hs ? (16'h0001 << r_svc_index) : 16'h0000;
  // A request re-asserted on its own handshake cycle re-arms the bit; it is not lost.
  assign w_lost_hit   = |(w_req & r_pending & ~w_clr_mask);

  // Next-state and gap-counter logic for the IDLE/OFFER/GAP sequencer.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_latch_idx = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_code_valid) begin
          w_state_nxt = S_OFFER;
          w_latch_idx = 1'b1;
        end
      end
      S_OFFER: begin
        // The offered index is held until accepted; later, higher requests wait.
        if (w_hs) begin
          if (GAP_CYCLES == 0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = GAP_LOAD;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == 4'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt - 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, pending, index and lost-count registers; all hold while ena is low.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state     <= S_IDLE;
      r_gap_cnt   <= 4'd0;
      r_pending   <= 16'h0000;
      r_svc_index <= 4'd0;
      r_lost      <= '0;
    end else if (ena) begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_pending <= (r_pending & ~w_clr_mask) | w_req;
      if (w_latch_idx) begin
        r_svc_index <= enc_code[3:0];
      end
      if (w_lost_hit && !(&r_lost)) begin
        r_lost <= r_lost + LOST_ONE;
      end
    end
  end

  assign pending   = r_pending;
  assign svc_index = r_svc_index;
  assign lost_cnt  = r_lost;
  assign busy      = (r_state != S_IDLE);
  // The offer is masked while the block is frozen and reappears unchanged afterwards.
  assign svc_valid = (r_state == S_OFFER) & ena;

endmodule
